// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
// Shadow stage entry layout and operand mux select encodings.
package hazard_pkg;

  localparam int RA_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            load;
  } stage_entry_t;

  localparam stage_entry_t STAGE_BUBBLE = '{
    valid: 1'b0,
    rd:    '0,
    load:  1'b0
  };

endpackage

// File: rtl/fwd_source_select.sv
// Operand forwarding select for one source register.
// Youngest valid writer wins: EX, then MEM, then WB.
module fwd_source_select
  import hazard_pkg::*;
(
  input  logic [RA_W-1:0] src,
  input  logic            used,
  input  stage_entry_t    ex,
  input  stage_entry_t    mem,
  input  stage_entry_t    wb,
  output logic [1:0]      sel
);

  logic live;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  assign live    = used && (src != '0);
  assign hit_ex  = live && ex.valid  && (ex.rd  == src);
  assign hit_mem = live && mem.valid && (mem.rd == src);
  assign hit_wb  = live && wb.valid  && (wb.rd  == src);

  // priority pick of the youngest producer
  always_comb begin
    sel = FWD_RF;
    if (hit_ex)       sel = FWD_EX;
    else if (hit_mem) sel = FWD_MEM;
    else if (hit_wb)  sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// Hazard detection and forwarding select generation beside ID.
// Tracks EX/MEM/WB writers in a private shadow pipeline.
module hazard_forwarding_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = RA_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic                  ID_rs1_used,
  input  logic                  ID_rs2_used,
  input  logic [REG_ADDR_W-1:0] ID_rd,
  input  logic                  ID_RF_Enable_IN,
  input  logic                  ID_Load_Instr_IN,
  input  logic                  EX_branch_taken,
  output logic [1:0]            fwd_sel_A,
  output logic [1:0]            fwd_sel_B,
  output logic                  CU_mux_sel,
  output logic                  PC_LE,
  output logic                  IF_ID_LE,
  output logic                  IF_ID_flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  stage_entry_t ex_q, mem_q, wb_q;
  stage_entry_t ex_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       hit1;
  logic       hit2;
  logic       load_use;
  logic       flush;
  logic       stall;

  fwd_source_select u_sel_a (
    .src  (ID_rs1),
    .used (ID_rs1_used),
    .ex   (ex_q),
    .mem  (mem_q),
    .wb   (wb_q),
    .sel  (sel_a)
  );

  fwd_source_select u_sel_b (
    .src  (ID_rs2),
    .used (ID_rs2_used),
    .ex   (ex_q),
    .mem  (mem_q),
    .wb   (wb_q),
    .sel  (sel_b)
  );

  assign hit1 = ID_rs1_used && (ID_rs1 != '0)
             && (ID_rs1 == ex_q.rd);
  assign hit2 = ID_rs2_used && (ID_rs2 != '0)
             && (ID_rs2 == ex_q.rd);

  assign load_use = ex_q.valid && ex_q.load
                 && (hit1 || hit2);

  // a taken branch squashes ID, so it overrides the load-use stall
  assign flush = !reset && EX_branch_taken;
  assign stall = !reset && load_use && !EX_branch_taken;

  // datapath steering; reset holds the front end with a bubble
  always_comb begin
    fwd_sel_A   = reset ? FWD_RF : sel_a;
    fwd_sel_B   = reset ? FWD_RF : sel_b;
    CU_mux_sel  = reset || stall || flush;
    PC_LE       = !reset && !stall;
    IF_ID_LE    = !reset && !stall;
    IF_ID_flush = flush;
  end

  // next EX entry: bubble on stall/flush, else the ID instruction
  always_comb begin
    ex_d = STAGE_BUBBLE;
    if (!stall && !flush) begin
      ex_d.valid = ID_RF_Enable_IN && (ID_rd != '0);
      ex_d.rd    = ID_rd;
      ex_d.load  = ID_Load_Instr_IN;
    end
  end

  // saturating event counter next-state
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // shadow pipeline and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= STAGE_BUBBLE;
      mem_q       <= STAGE_BUBBLE;
      wb_q        <= STAGE_BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Scoreboard bench for hazard_forwarding_unit.
// Reference keeps a history of issued instructions, youngest first.
module tb_hazard_forwarding_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ID_rs1 = '0;
  logic [4:0]  ID_rs2 = '0;
  logic        ID_rs1_used = 1'b0;
  logic        ID_rs2_used = 1'b0;
  logic [4:0]  ID_rd = '0;
  logic        ID_RF_Enable_IN = 1'b0;
  logic        ID_Load_Instr_IN = 1'b0;
  logic        EX_branch_taken = 1'b0;
  logic [1:0]  fwd_sel_A;
  logic [1:0]  fwd_sel_B;
  logic        CU_mux_sel;
  logic        PC_LE;
  logic        IF_ID_LE;
  logic        IF_ID_flush;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  hazard_forwarding_unit #(
    .REG_ADDR_W (5),
    .CNT_W      (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ID_rs1           (ID_rs1),
    .ID_rs2           (ID_rs2),
    .ID_rs1_used      (ID_rs1_used),
    .ID_rs2_used      (ID_rs2_used),
    .ID_rd            (ID_rd),
    .ID_RF_Enable_IN  (ID_RF_Enable_IN),
    .ID_Load_Instr_IN (ID_Load_Instr_IN),
    .EX_branch_taken  (EX_branch_taken),
    .fwd_sel_A        (fwd_sel_A),
    .fwd_sel_B        (fwd_sel_B),
    .CU_mux_sel       (CU_mux_sel),
    .PC_LE            (PC_LE),
    .IF_ID_LE         (IF_ID_LE),
    .IF_ID_flush      (IF_ID_flush),
    .stall_count      (stall_count),
    .flush_count      (flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit writes;
    int rd;
    bit load;
  } ins_t;

  typedef struct {
    int fa;
    int fb;
    int cu;
    int pcle;
    int ifle;
    int fl;
    int sc;
    int fc;
  } exp_t;

  ins_t hist[$];
  exp_t sbq[$];
  int   m_sc;
  int   m_fc;
  int   checks = 0;
  int   errors = 0;

  task automatic clear_model();
    ins_t b;
    b.writes = 0;
    b.rd = 0;
    b.load = 0;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(b);
    m_sc = 0;
    m_fc = 0;
  endtask

  // age of the youngest in-flight writer of src: 1=EX .. 3=WB
  function automatic int ref_fwd(int src, bit used);
    if (!used || src == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (hist[i].writes && hist[i].rd == src) return i + 1;
    return 0;
  endfunction

  task automatic chk(string name, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic drive(int rs1, int rs2, bit u1, bit u2,
                       int rd, bit rfen, bit ld, bit br,
                       bit rst);
    exp_t e;
    ins_t n;
    bit   hz;
    bit   st;
    @(posedge clk);
    #1;
    ID_rs1 = 5'(rs1);
    ID_rs2 = 5'(rs2);
    ID_rs1_used = u1;
    ID_rs2_used = u2;
    ID_rd = 5'(rd);
    ID_RF_Enable_IN = rfen;
    ID_Load_Instr_IN = ld;
    EX_branch_taken = br;
    reset = rst;
    if (rst) begin
      clear_model();
      e = '{0, 0, 1, 0, 0, 0, 0, 0};
      sbq.push_back(e);
      return;
    end
    hz = hist[0].writes && hist[0].load &&
         ((u1 && rs1 != 0 && rs1 == hist[0].rd) ||
          (u2 && rs2 != 0 && rs2 == hist[0].rd));
    st = hz && !br;
    e.fa = ref_fwd(rs1, u1);
    e.fb = ref_fwd(rs2, u2);
    e.cu = (st || br) ? 1 : 0;
    e.pcle = st ? 0 : 1;
    e.ifle = st ? 0 : 1;
    e.fl = br ? 1 : 0;
    e.sc = m_sc;
    e.fc = m_fc;
    sbq.push_back(e);
    if (st) m_sc++;
    if (br) m_fc++;
    n.writes = 0;
    n.rd = 0;
    n.load = 0;
    if (!st && !br) begin
      n.writes = rfen && rd != 0;
      n.rd = rd;
      n.load = ld;
    end
    hist.push_front(n);
    void'(hist.pop_back());
  endtask

  // monitor: compare the DUT against each queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("fwd_sel_A", int'(fwd_sel_A), e.fa);
        chk("fwd_sel_B", int'(fwd_sel_B), e.fb);
        chk("CU_mux_sel", int'(CU_mux_sel), e.cu);
        chk("PC_LE", int'(PC_LE), e.pcle);
        chk("IF_ID_LE", int'(IF_ID_LE), e.ifle);
        chk("IF_ID_flush", int'(IF_ID_flush), e.fl);
        chk("stall_count", int'(stall_count), e.sc);
        chk("flush_count", int'(flush_count), e.fc);
      end
    end
  end

  initial begin
    int guard;
    clear_model();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // ALU x5 then reads at EX/MEM/WB distance and beyond
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0);
    drive(5, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(5, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(5, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(5, 0, 1, 0, 0, 0, 0, 0, 0);
    // x5 in MEM and EX, both sources read x5
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0);
    drive(5, 5, 1, 1, 0, 0, 0, 0, 0);
    // load-use on rs2, then MEM forward
    drive(0, 0, 0, 0, 7, 1, 1, 0, 0);
    drive(0, 7, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 7, 0, 1, 0, 0, 0, 0, 0);
    // x0 never forwards; unused source never forwards
    drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 5, 1, 0, 0, 0);
    drive(5, 0, 0, 0, 0, 0, 0, 0, 0);
    // flush beats a simultaneous load-use stall
    drive(0, 0, 0, 0, 7, 1, 1, 0, 0);
    drive(7, 0, 1, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset raised in the middle of a stall cycle
    drive(0, 0, 0, 0, 9, 1, 1, 0, 0);
    drive(9, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(9, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 9, 1, 1, 0, 0);
    drive(9, 0, 1, 0, 0, 0, 0, 0, 1);
    drive(9, 0, 1, 0, 0, 0, 0, 0, 0);
    // randomized traffic over a small register window
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 7),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 63) == 0));
    end
    guard = 0;
    while (sbq.size() > 0 && guard < 5) begin
      @(posedge clk);
      guard++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain left %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
